// File: rtl/spi_cfg_bridge.sv
// rtl/spi_cfg_bridge.sv - SPI slave to config register bridge
// Receives {RW, address, data} frames MSB first on an asynchronous SPI link,
// issues one-cycle register writes or returns register read data on miso.
module spi_cfg_bridge #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              cfg_write,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [DATA_W-1:0] cfg_wdata,
  input  logic [DATA_W-1:0] cfg_rdata,
  output logic              frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int HDR_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;

  // Synchronizer stages plus one delayed copy for edge detection
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_mosi_s1, r_mosi_s2;

  // Counts cycles after reset so the synchronizer flush is not seen as a cs_n fall
  logic [1:0] r_settle;

  // The newest bit lives in mosi, so DATA_W-1 stored bits complete a data word
  logic [DATA_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_rw;
  logic [1:0]        r_rd_dly;
  logic [DATA_W-1:0] r_tx;

  logic              r_miso;
  logic              r_cfg_write;
  logic [ADDR_W-1:0] r_cfg_address;
  logic [DATA_W-1:0] r_cfg_wdata;
  logic              r_frame_err;

  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_fall;
  logic [DATA_W-1:0] w_shift_next;

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall  = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall    = ~r_cs_s2 & r_cs_d & (r_settle == 2'd3);
  assign w_shift_next = {r_shift, r_mosi_s2};

  assign miso        = r_miso;
  assign cfg_write   = r_cfg_write;
  assign cfg_address = r_cfg_address;
  assign cfg_wdata   = r_cfg_wdata;
  assign frame_err   = r_frame_err;

  // Two-flop synchronizers; idle levels are cs_n high and sclk low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Post-reset settle counter: a cs_n held low through reset must not start a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle <= 2'd0;
    end else if (r_settle != 2'd3) begin
      r_settle <= r_settle + 2'd1;
    end
  end

  // Frame FSM: shifts in header and data, drives the register port and miso
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_rw          <= 1'b0;
      r_rd_dly      <= 2'd0;
      r_tx          <= '0;
      r_miso        <= 1'b0;
      r_cfg_write   <= 1'b0;
      r_cfg_address <= '0;
      r_cfg_wdata   <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_cfg_write <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso    <= 1'b0;
          r_bit_cnt <= '0;
          r_shift   <= '0;
          r_rd_dly  <= 2'd0;
          if (w_cs_fall) begin
            r_state <= HDR;
          end
        end
        HDR: begin
          if (r_cs_s2) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else if (w_sclk_rise) begin
            r_shift   <= w_shift_next[DATA_W-2:0];
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(HDR_LEN - 1)) begin
              r_cfg_address <= w_shift_next[ADDR_W-1:0];
              r_rw          <= w_shift_next[ADDR_W];
              // Read: address is out next cycle, rdata settles one cycle later
              if (!w_shift_next[ADDR_W]) begin
                r_rd_dly <= 2'd3;
              end
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (r_cs_s2) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_rd_dly    <= 2'd0;
          end else begin
            if (w_sclk_rise) begin
              r_shift   <= w_shift_next[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                if (r_rw) begin
                  r_cfg_write <= 1'b1;
                  r_cfg_wdata <= w_shift_next;
                end
                r_state <= COMMIT;
              end
            end
            if (w_sclk_fall && !r_rw) begin
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            // Load placed last so it takes precedence over a shift in the same cycle
            if (r_rd_dly != 2'd0) begin
              r_rd_dly <= r_rd_dly - 2'd1;
              if (r_rd_dly == 2'd1) begin
                r_tx <= cfg_rdata;
              end
            end
          end
        end
        COMMIT: begin
          if (w_sclk_fall) begin
            r_miso <= 1'b0;
          end
          r_state <= DONE;
        end
        DONE: begin
          // Extra clocks of an over-length frame are ignored; miso returns low
          if (w_sclk_fall) begin
            r_miso <= 1'b0;
          end
          if (r_cs_s2) begin
            r_miso  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_bridge.sv
// tb/tb_spi_cfg_bridge.sv - directed vector bench for spi_cfg_bridge
module tb_spi_cfg_bridge;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        cfg_write;
  logic [2:0]  cfg_address;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        frame_err;

  logic [15:0] regs [8];
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  int          err_count = 0;
  logic [2:0]  last_waddr = '0;
  logic [15:0] last_wdata = '0;

  typedef struct {
    logic [31:0] bits;
    int          len;
    int          sent;
    int          exp_wr;
    int          exp_err;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    bit          is_read;
  } vec_t;

  vec_t vecs[22];

  spi_cfg_bridge #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso),
    .cfg_write(cfg_write),
    .cfg_address(cfg_address),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rst_val(input int a);
    logic [15:0] v;
    v = 16'h1357 + 16'h1111 * a[15:0];
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic rw, input logic [2:0] a, input logic [15:0] d);
    return {12'b0, rw, a, d};
  endfunction

  function automatic vec_t mkv(input logic [31:0] bits, input int len, input int sent,
                               input int wr, input int err, input logic [2:0] a,
                               input logic [15:0] d, input bit rd);
    vec_t v;
    v.bits = bits; v.len = len; v.sent = sent; v.exp_wr = wr; v.exp_err = err;
    v.exp_addr = a; v.exp_data = d; v.is_read = rd;
    return v;
  endfunction

  // Config register block model
  assign cfg_rdata = regs[cfg_address];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= rst_val(i);
    end else if (cfg_write) begin
      regs[cfg_address] <= cfg_wdata;
    end
  end

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (cfg_write) begin
      wr_count   <= wr_count + 1;
      last_waddr <= cfg_address;
      last_wdata <= cfg_wdata;
    end
    if (frame_err) err_count <= err_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [31:0] bits, input int len, input int sent,
                          input bit keep_cs, output logic [31:0] rx, output logic miso_tail);
    rx = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < sent; i++) begin
      mosi = bits[len-1-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    miso_tail = miso;
    if (!keep_cs) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rx;
    logic        tail;
    int          w0;
    int          e0;

    vecs[0] = mkv(mk(1'b1, 3'd0, 16'h0000), 20, 20, 1, 0, 3'd0, 16'h0000, 1'b0);
    vecs[1] = mkv(mk(1'b1, 3'd4, 16'hABCD), 20, 20, 1, 0, 3'd4, 16'hABCD, 1'b0);
    vecs[2] = mkv(mk(1'b0, 3'd4, 16'h0000), 20, 20, 0, 0, 3'd4, 16'hABCD, 1'b1);
    vecs[3] = mkv(mk(1'b1, 3'd7, 16'hFFFE), 20, 10, 0, 1, 3'd7, 16'h0000, 1'b0);
    vecs[4] = mkv(mk(1'b1, 3'd7, 16'hFFFE), 20, 20, 1, 0, 3'd7, 16'hFFFE, 1'b0);
    vecs[5] = mkv((mk(1'b1, 3'd6, 16'h1234) << 4) | 32'hA, 24, 24, 1, 0, 3'd6, 16'h1234, 1'b0);
    for (int a = 0; a < 8; a++) begin
      vecs[6+a]  = mkv(mk(1'b1, 3'(a), ~rst_val(a)), 20, 20, 1, 0, 3'(a), ~rst_val(a), 1'b0);
      vecs[14+a] = mkv(mk(1'b0, 3'(a), 16'h0000), 20, 20, 0, 0, 3'(a), ~rst_val(a), 1'b1);
    end

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_cfg_write", {31'b0, cfg_write}, 32'd0);
    check("rst_cfg_address", {29'b0, cfg_address}, 32'd0);
    check("rst_cfg_wdata", {16'b0, cfg_wdata}, 32'd0);
    check("rst_miso", {31'b0, miso}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_quiet", wr_count + err_count, 32'd0);

    // Table of frames
    for (int i = 0; i < 22; i++) begin
      w0 = wr_count;
      e0 = err_count;
      spi_xfer(vecs[i].bits, vecs[i].len, vecs[i].sent, 1'b0, rx, tail);
      check($sformatf("v%0d_writes", i), wr_count - w0, vecs[i].exp_wr);
      check($sformatf("v%0d_errs", i), err_count - e0, vecs[i].exp_err);
      check($sformatf("v%0d_addr", i), {29'b0, cfg_address}, {29'b0, vecs[i].exp_addr});
      if (vecs[i].exp_wr != 0) begin
        check($sformatf("v%0d_waddr", i), {29'b0, last_waddr}, {29'b0, vecs[i].exp_addr});
        check($sformatf("v%0d_wdata", i), {16'b0, last_wdata}, {16'b0, vecs[i].exp_data});
      end
      if (vecs[i].is_read) begin
        check($sformatf("v%0d_rdata", i), {16'b0, rx[15:0]}, {16'b0, vecs[i].exp_data});
        check($sformatf("v%0d_miso_tail", i), {31'b0, tail}, 32'd0);
      end else begin
        check($sformatf("v%0d_miso_quiet", i), rx, 32'd0);
      end
    end

    // Reset in the middle of a write frame
    w0 = wr_count;
    e0 = err_count;
    spi_xfer(mk(1'b1, 3'd5, 16'h5A5A), 20, 12, 1'b1, rx, tail);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_cfg_address", {29'b0, cfg_address}, 32'd0);
    check("midrst_cfg_wdata", {16'b0, cfg_wdata}, 32'd0);
    check("midrst_cfg_write", {31'b0, cfg_write}, 32'd0);
    check("midrst_miso", {31'b0, miso}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
    check("midrst_no_write", wr_count - w0, 32'd0);
    check("midrst_no_err", err_count - e0, 32'd0);
    spi_xfer(mk(1'b1, 3'd5, 16'h5A5A), 20, 20, 1'b0, rx, tail);
    check("postrst_writes", wr_count - w0, 32'd1);
    check("postrst_waddr", {29'b0, last_waddr}, 32'd5);
    check("postrst_wdata", {16'b0, last_wdata}, 32'h5A5A);

    // sclk activity with cs_n high
    w0 = wr_count;
    e0 = err_count;
    for (int k = 0; k < 5; k++) begin
      mosi = k[0];
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("csh_no_write", wr_count - w0, 32'd0);
    check("csh_no_err", err_count - e0, 32'd0);
    check("csh_miso", {31'b0, miso}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
